ps2_event_decoder: RTL and testbench

- Single-clock successor to the keyboard-to-game-event path. Consumes raw PS2 scancode bytes, tracks make/break and E0-extended prefixes, and maps keys to game events.
- Adds configurable auto-repeat for held movement keys and suppresses the keyboard's own typematic repeats.
- Buffers events in a parametrised show-ahead FIFO that the main game logic reads with a request pulse.

---
 rtl/tetris_input_pkg.sv | 62 ++++++
 rtl/ev_fifo.sv | 53 +++++
 rtl/ps2_event_decoder.sv | 162 ++++++++++++++++
 tb/tb_ps2_event_decoder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_input_pkg.sv
// Shared definitions for the PS2 keyboard to game-event path: event codes,
// scancodes, the prefix FSM states and the scancode-to-event mapping.
package tetris_input_pkg;

  localparam int EV_W     = 3;
  localparam int NUM_KEYS = 6;  // mapped keys, event codes 1..6
  localparam int NUM_REP  = 3;  // auto-repeating keys, event codes 1..3

  typedef enum logic [EV_W-1:0] {
    EV_NONE     = 3'd0,
    EV_LEFT     = 3'd1,
    EV_RIGHT    = 3'd2,
    EV_DOWN     = 3'd3,
    EV_ROTATE   = 3'd4,
    EV_DROP     = 3'd5,
    EV_NEW_GAME = 3'd6
  } event_e;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_ROTATE = 8'h75;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_e;

  // Movement keys auto-repeat while held; the rest fire once per press.
  function automatic logic ev_is_repeatable(event_e ev);
    return (ev == EV_LEFT) || (ev == EV_RIGHT) || (ev == EV_DOWN);
  endfunction

  // Arrow keys only exist behind the E0 prefix; space/enter only without it.
  function automatic event_e scan_to_event(logic ext, logic [7:0] sc);
    event_e ev;
    ev = EV_NONE;
    if (ext) begin
      case (sc)
        SC_LEFT:   ev = EV_LEFT;
        SC_RIGHT:  ev = EV_RIGHT;
        SC_DOWN:   ev = EV_DOWN;
        SC_ROTATE: ev = EV_ROTATE;
        default:   ev = EV_NONE;
      endcase
    end else begin
      case (sc)
        SC_SPACE:  ev = EV_DROP;
        SC_ENTER:  ev = EV_NEW_GAME;
        default:   ev = EV_NONE;
      endcase
    end
    return ev;
  endfunction

endpackage

// File: rtl/ev_fifo.sv
// Show-ahead synchronous FIFO. Head entry is always visible on rd_data_o
// (zero while empty). A write while full is accepted only if a pop happens
// in the same cycle.
module ev_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push, pop;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop       = rd_en_i & ~empty_o;
  assign push      = wr_en_i & (~full_o | pop);
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; the extra MSB distinguishes full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/ps2_event_decoder.sv
// PS2 scancode stream to game events: prefix FSM, held-key tracking with
// typematic suppression, per-key auto-repeat for movement keys, and a
// single-write-per-cycle arbiter feeding a show-ahead event FIFO.
module ps2_event_decoder
  import tetris_input_pkg::*;
#(
  parameter int EVENT_W       = 3,
  parameter int FIFO_DEPTH    = 8,
  parameter int REPEAT_DELAY  = 30000000,
  parameter int REPEAT_PERIOD = 8000000,
  parameter int CNT_W         = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [7:0]         ps2_key_data_i,
  input  logic               ps2_key_data_en_i,
  input  logic               user_event_rd_req_i,
  output logic [EVENT_W-1:0] user_event_o,
  output logic               user_event_ready_o,
  output logic               overflow_o,
  output logic [5:0]         held_keys_o
);

  prefix_e                          state_q, state_d;
  event_e                           dec_ev;
  logic                             dec_make, dec_brk, new_make;
  logic [NUM_KEYS-1:0]              dec_onehot, held_q, held_d;
  event_e                           push_q, push_d;
  logic [NUM_REP-1:0][CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REP-1:0]               pend_q, pend_d, grant;
  logic                             wr_en, fifo_full, fifo_empty;
  event_e                           wr_ev;
  logic                             overflow_q, overflow_d;

  // Prefix FSM: classifies each strobed byte as make/break, normal/extended.
  always_comb begin
    state_d  = state_q;
    dec_ev   = EV_NONE;
    dec_make = 1'b0;
    dec_brk  = 1'b0;
    if (ps2_key_data_en_i) begin
      case (state_q)
        ST_IDLE: begin
          if (ps2_key_data_i == SC_EXT)      state_d = ST_EXT;
          else if (ps2_key_data_i == SC_BRK) state_d = ST_BRK;
          else begin
            dec_ev   = scan_to_event(1'b0, ps2_key_data_i);
            dec_make = 1'b1;
          end
        end
        ST_EXT: begin
          if (ps2_key_data_i == SC_BRK) state_d = ST_EXT_BRK;
          else begin
            dec_ev   = scan_to_event(1'b1, ps2_key_data_i);
            dec_make = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          dec_ev  = scan_to_event(1'b0, ps2_key_data_i);
          dec_brk = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          dec_ev  = scan_to_event(1'b1, ps2_key_data_i);
          dec_brk = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Held-key update; a make of an already-held key is keyboard typematic.
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) dec_onehot[i] = (int'(dec_ev) == i + 1);
    new_make = dec_make && |(dec_onehot & ~held_q);
    held_d   = held_q;
    if (new_make) held_d = held_q | dec_onehot;
    if (dec_brk)  held_d = held_q & ~dec_onehot;
    push_d   = new_make ? dec_ev : EV_NONE;
  end

  // Write arbiter: registered make first, then pending LEFT, RIGHT, DOWN.
  always_comb begin
    wr_en = 1'b0;
    wr_ev = EV_NONE;
    grant = '0;
    if (push_q != EV_NONE) begin
      wr_en = 1'b1;
      wr_ev = push_q;
    end else begin
      for (int k = 0; k < NUM_REP; k++) begin
        if (!wr_en && pend_q[k]) begin
          wr_en    = 1'b1;
          wr_ev    = event_e'(k + 1);
          grant[k] = 1'b1;
        end
      end
    end
  end

  // Auto-repeat counters; a granted pending bit clears even if the write is dropped.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q & ~grant;
    for (int k = 0; k < NUM_REP; k++) begin
      if (dec_brk && dec_onehot[k]) begin
        cnt_d[k]  = '0;
        pend_d[k] = 1'b0;
      end else if (new_make && ev_is_repeatable(dec_ev) && dec_onehot[k]) begin
        cnt_d[k] = CNT_W'(REPEAT_DELAY);
      end else if (held_q[k]) begin
        if (cnt_q[k] <= CNT_W'(1)) begin
          pend_d[k] = 1'b1;
          cnt_d[k]  = CNT_W'(REPEAT_PERIOD);
        end else begin
          cnt_d[k] = cnt_q[k] - 1'b1;
        end
      end
    end
    overflow_d = overflow_q |
                 (wr_en & fifo_full & ~(user_event_rd_req_i & ~fifo_empty));
  end

  // Decoder, held-key, repeat and overflow state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      held_q     <= '0;
      push_q     <= EV_NONE;
      cnt_q      <= '0;
      pend_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      push_q     <= push_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      overflow_q <= overflow_d;
    end
  end

  ev_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en),
    .wr_data_i (EVENT_W'(wr_ev)),
    .rd_en_i   (user_event_rd_req_i),
    .rd_data_o (user_event_o),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign user_event_ready_o = ~fifo_empty;
  assign overflow_o         = overflow_q;
  assign held_keys_o        = held_q;

endmodule

// File: tb/tb_ps2_event_decoder.sv
// Bench for ps2_event_decoder: reset check, a vector table, directed
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_ps2_event_decoder;

  localparam int DEPTH = 4;
  localparam int DLY   = 100;
  localparam int PER   = 20;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       en    = 1'b0;
  logic       rd    = 1'b0;
  logic [2:0] ev;
  logic       rdy, ovf;
  logic [5:0] held;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  ps2_event_decoder #(
    .EVENT_W(3), .FIFO_DEPTH(DEPTH), .REPEAT_DELAY(DLY),
    .REPEAT_PERIOD(PER), .CNT_W(32)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ps2_key_data_i(data),
    .ps2_key_data_en_i(en), .user_event_rd_req_i(rd),
    .user_event_o(ev), .user_event_ready_o(rdy),
    .overflow_o(ovf), .held_keys_o(held)
  );

  // ---------------- reference model ----------------
  int      cyc;
  bit      m_held [1:6];
  longint  next_rep [1:3];
  bit      m_pend [1:3];
  int      push_nx;
  int      q[$];
  bit      m_ovf, m_ext, m_brk;

  function automatic int map_sc(bit ext, logic [7:0] b);
    if (ext) begin
      case (b)
        8'h6B: return 1;
        8'h74: return 2;
        8'h72: return 3;
        8'h75: return 4;
        default: return 0;
      endcase
    end
    case (b)
      8'h29: return 5;
      8'h5A: return 6;
      default: return 0;
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 1; i <= 6; i++) m_held[i] = 0;
    for (int i = 1; i <= 3; i++) begin m_pend[i] = 0; next_rep[i] = 0; end
    push_nx = 0; q.delete(); m_ovf = 0; m_ext = 0; m_brk = 0; cyc = 0;
  endtask

  // One clock edge of the spec's behaviour, using the inputs present at it.
  task automatic m_edge();
    int w = 0;
    int gk = 0;
    int c;
    bit full = (q.size() == DEPTH);
    bit popd = 0;
    if (push_nx != 0) w = push_nx;
    else for (int k = 1; k <= 3; k++) if (w == 0 && m_pend[k]) begin w = k; gk = k; end
    if (rd && q.size() > 0) begin void'(q.pop_front()); popd = 1; end
    if (w != 0) begin
      if (!full || popd) q.push_back(w);
      else m_ovf = 1;
    end
    if (gk != 0) m_pend[gk] = 0;
    push_nx = 0;
    for (int k = 1; k <= 3; k++)
      if (m_held[k] && cyc == next_rep[k]) begin m_pend[k] = 1; next_rep[k] += PER; end
    if (en) begin
      if (m_brk) begin
        c = map_sc(m_ext, data);
        if (c != 0) begin m_held[c] = 0; if (c <= 3) m_pend[c] = 0; end
        m_ext = 0; m_brk = 0;
      end else if (data == 8'hF0) m_brk = 1;
      else if (data == 8'hE0 && !m_ext) m_ext = 1;
      else begin
        c = map_sc(m_ext, data);
        if (c != 0 && !m_held[c]) begin
          m_held[c] = 1; push_nx = c;
          if (c <= 3) next_rep[c] = cyc + DLY;
        end
        m_ext = 0;
      end
    end
    cyc++;
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Advance one clock, update the model, compare all outputs to it.
  task automatic step();
    logic [5:0] eh;
    int         ee;
    @(posedge clk_i); #1;
    if (rst_i) m_edge();
    eh = '0;
    for (int i = 1; i <= 6; i++) eh[i-1] = m_held[i];
    ee = (q.size() > 0) ? q[0] : 0;
    checks++;
    if ({ev, rdy, ovf, held} !== {3'(ee), q.size() > 0, m_ovf, eh}) begin
      errors++;
      $display("FAIL model cyc %0d: got ev=%0d rdy=%0b ovf=%0b held=%b want ev=%0d rdy=%0b ovf=%0b held=%b",
               cyc, ev, rdy, ovf, held, ee, q.size() > 0, m_ovf, eh);
    end
  endtask

  task automatic send(logic [7:0] b);
    en = 1'b1; data = b; step(); en = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b0; m_reset(); step(); step(); rst_i = 1'b1;
  endtask

  int coll[$];

  // Idle cycles, popping whenever an event is available and recording it.
  task automatic pop_idle(int n);
    for (int i = 0; i < n; i++) begin
      rd = rdy;
      if (rdy) coll.push_back(int'(ev));
      step();
    end
    rd = 1'b0;
  endtask

  typedef struct {
    bit         en;
    logic [7:0] b;
    bit         rd;
    logic       rdy;
    logic [2:0] ev;
    logic [5:0] held;
  } vec_t;

  vec_t tbl[19];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit all2;
    int exp4[4];
    tbl[0]  = '{1, 8'h29, 0, 0, 0, 6'b010000};
    tbl[1]  = '{1, 8'h29, 0, 1, 5, 6'b010000};
    tbl[2]  = '{1, 8'h29, 0, 1, 5, 6'b010000};
    tbl[3]  = '{1, 8'hF0, 0, 1, 5, 6'b010000};
    tbl[4]  = '{1, 8'h29, 0, 1, 5, 6'b000000};
    tbl[5]  = '{0, 8'h00, 1, 0, 0, 6'b000000};
    tbl[6]  = '{0, 8'h00, 0, 0, 0, 6'b000000};
    tbl[7]  = '{1, 8'hE0, 0, 0, 0, 6'b000000};
    tbl[8]  = '{1, 8'h75, 0, 0, 0, 6'b001000};
    tbl[9]  = '{0, 8'h00, 0, 1, 4, 6'b001000};
    tbl[10] = '{1, 8'hE0, 1, 0, 0, 6'b001000};
    tbl[11] = '{1, 8'hF0, 0, 0, 0, 6'b001000};
    tbl[12] = '{1, 8'h75, 0, 0, 0, 6'b000000};
    tbl[13] = '{1, 8'h5A, 0, 0, 0, 6'b100000};
    tbl[14] = '{0, 8'h00, 0, 1, 6, 6'b100000};
    tbl[15] = '{1, 8'h6B, 0, 1, 6, 6'b100000};
    tbl[16] = '{0, 8'h00, 1, 0, 0, 6'b100000};
    tbl[17] = '{1, 8'hF0, 0, 0, 0, 6'b100000};
    tbl[18] = '{1, 8'h5A, 0, 0, 0, 6'b000000};

    do_reset();
    chk("reset_ev", ev, 0);
    chk("reset_rdy", rdy, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_held", held, 0);

    // Vector table.
    for (int i = 0; i < 19; i++) begin
      en = tbl[i].en; data = tbl[i].b; rd = tbl[i].rd;
      step();
      en = 1'b0; rd = 1'b0;
      chk($sformatf("tbl%0d_rdy", i), rdy, tbl[i].rdy);
      chk($sformatf("tbl%0d_ev", i), ev, tbl[i].ev);
      chk($sformatf("tbl%0d_held", i), held, tbl[i].held);
    end

    // LEFT press/release: one event, ready two cycles after the strobe.
    send(8'hE0); send(8'h6B);
    chk("left_held_set", held, 6'b000001);
    chk("left_rdy_n1", rdy, 0);
    step();
    chk("left_rdy_n2", rdy, 1);
    chk("left_ev", ev, 1);
    for (int i = 0; i < 19; i++) step();
    send(8'hE0); send(8'hF0); send(8'h6B);
    chk("left_held_clr", held, 0);
    chk("left_still_one", ev, 1);
    rd = 1'b1; step(); rd = 1'b0;
    chk("left_only_one", rdy, 0);

    // Held RIGHT auto-repeats, stops on break.
    coll.delete();
    send(8'hE0); send(8'h74);
    pop_idle(165);
    send(8'hE0); send(8'hF0); send(8'h74);
    pop_idle(60);
    chk("rep_count", coll.size(), 5);
    all2 = 1;
    foreach (coll[i]) if (coll[i] != 2) all2 = 0;
    chk("rep_all_right", all2, 1);
    chk("rep_held_clr", held, 0);

    // Overflow: six NEW_GAME presses, no reads.
    for (int i = 0; i < 6; i++) begin send(8'h5A); send(8'hF0); send(8'h5A); end
    step();
    chk("ovf_set", ovf, 1);
    chk("ovf_rdy", rdy, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_pop%0d", i), ev, 6);
      rd = 1'b1; step(); rd = 1'b0;
    end
    chk("ovf_drained", rdy, 0);
    chk("ovf_sticky", ovf, 1);

    // Full FIFO with a pop in the same cycle as the ROTATE write.
    do_reset();
    send(8'h5A); send(8'hF0); send(8'h5A);
    send(8'h29); send(8'hF0); send(8'h29);
    send(8'h5A); send(8'hF0); send(8'h5A);
    send(8'h29); send(8'hF0); send(8'h29);
    step();
    chk("full_head", ev, 6);
    send(8'hE0); send(8'h75);
    rd = 1'b1; step(); rd = 1'b0;
    chk("full_pp_ovf", ovf, 0);
    exp4 = '{5, 6, 5, 4};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full_pp_pop%0d", i), ev, exp4[i]);
      rd = 1'b1; step(); rd = 1'b0;
    end
    chk("full_pp_empty", rdy, 0);
    chk("full_pp_ovf_end", ovf, 0);

    // Asynchronous reset right after an E0 prefix.
    do_reset();
    send(8'h5A); step();
    send(8'hE0);
    #2 rst_i = 1'b0; #1;
    chk("arst_ev", ev, 0);
    chk("arst_rdy", rdy, 0);
    chk("arst_held", held, 0);
    chk("arst_ovf", ovf, 0);
    m_reset(); step(); rst_i = 1'b1;
    send(8'h6B); step(); step();
    chk("arst_6b_rdy", rdy, 0);
    chk("arst_6b_held", held, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] pick [10];
      pick = '{8'hE0, 8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h72, 8'h75, 8'h29, 8'h5A, 8'h00};
      pick[9] = 8'($urandom);
      en   = ($urandom_range(0, 5) == 0);
      data = pick[$urandom_range(0, 9)];
      rd   = (i < 2000) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 0);
      step();
    end
    en = 1'b0; rd = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
